can_rx_accept_logic: RTL and testbench
======================================

Name: can_rx_accept_logic

Overview:
- Receive-side counterpart of the TX priority path.
- Takes a completed 128-bit frame from the CAN-clock bit-stream processor over a req/ack handshake, synchronizes the request into i_sys_clk, and runs acceptance filtering (AFR/AFMR/AFIR).
- Writes accepted frames into the RX FIFO and raises RXOK/RXOFLW status pulses for the interrupt block.

Parameters:
- NUM_FILTERS, 4, number of acceptance mask/ID pairs (1..4).
- FRAME_W, 128, frame width: ID word, DLC word, DW1, DW2.

Ports:
- i_sys_clk  in  1  system clock.
- i_reset  in  1  reset.
- i_cen  in  1  core enable (SRR.CEN).
- i_rx_req  in  1  frame-ready level from CAN domain; i_rx_frame stable while high.
- i_rx_frame  in  FRAME_W  received frame: [127:96] ID word, [95:64] DLC word, [63:32] DW1, [31:0] DW2.
- i_afr  in  NUM_FILTERS  per-filter enable (UAF bits).
- i_afmr  in  32*NUM_FILTERS  mask registers; filter k at [32k+31:32k].
- i_afir  in  32*NUM_FILTERS  ID registers, same packing.
- i_rx_full  in  1  RX FIFO full.
- o_rx_ack  out  1  registered ack to CAN domain; CAN side double-syncs.
- o_fifo_w_en  out  1  RX FIFO write strobe.
- o_fifo_w_data  out  FRAME_W  RX FIFO write data.
- o_rxok  out  1  one-cycle pulse, frame stored.
- o_rxofl  out  1  one-cycle pulse, accepted frame dropped because FIFO full.

Behaviour:
- Clock and reset: clock i_sys_clk; reset i_reset, asynchronous, active-high.
- Reset values: all outputs 0, frame register 0, sync flops 0, state IDLE.
- Synchronizer: i_rx_req → t_req → s_req (2 flops); i_rx_frame is never synchronized, only captured while s_req=1 (req/ack protocol guarantees stability).
- Acceptance:
  - Filter k matches when i_afr[k]=1 and ((id ^ afir_k) & afmr_k)==0, where id is the ID word.
  - accept = (i_afr==0) OR any filter matches.
  - i_afr all-zero means filtering is disabled and every frame is accepted.
- FSM states and transitions:
  - IDLE: if s_req=1, load frame register from i_rx_frame, go to FILTER; otherwise stay.
  - FILTER: evaluate accept, i_cen and i_rx_full combinationally; at the exit edge register the strobes:
    - w_en = cen & accept & ~full
    - rxok = w_en
    - rxofl = cen & accept & full
  - FILTER then goes to STORE.
  - STORE: strobes are high for exactly this one cycle; o_fifo_w_data = frame register (held until next load); go to ACK.
  - ACK: o_rx_ack=1 (registered, set on entry); when s_req=0, clear o_rx_ack and go to IDLE.
- Latency (E0 = first sys edge sampling i_rx_req=1):
  - s_req=1 after E1.
  - Frame loaded and state FILTER at E2.
  - o_fifo_w_en/o_rxok/o_rxofl high during the cycle after E3.
  - o_rx_ack high after E4.
  - Minimum IDLE-to-IDLE is 5 cycles plus handshake return time.
- Boundary conditions:
  - i_cen=0: frame still acked (no CAN-side deadlock); no strobes, no flags.
  - Rejected frame: acked; no strobes.
  - FIFO full: frame dropped; o_rxofl pulse; FIFO contents untouched.
  - i_cen, i_afr/i_afmr/i_afir and i_rx_full are sampled only at the FILTER→STORE edge; changes at any other time do not affect the frame in flight.
  - i_rx_req held high after ack: no second processing; req must return to 0 (s_req=0) before the next frame.
  - Back-to-back frames: the next frame is processed only after a full req-low/high cycle; none are lost or duplicated.
  - Reset mid-operation (any state): immediate clear; in-flight frame discarded, no partial write, o_rx_ack low.
- Width rules:
  - All comparisons are full 32-bit, including SRR/IDE/RTR bits.
  - Software masks those bits via AFMR.
  - Filters k ≥ NUM_FILTERS do not exist.

Decomposition:
- Package can_rx_pkg:
  - state enum (IDLE, FILTER, STORE, ACK);
  - frame field offsets (ID_HI, ID_LO, DLC_HI, DW1_HI, DW2_HI);
  - ID word bit positions (IDH [31:21], SRR 20, IDE 19, IDL [18:1], RTR 0);
  - default NUM_FILTERS.
- Sub-module can_acceptance_filter: combinational, takes id, i_afr, i_afmr, i_afir; outputs accept. It is reused by any future RX-side debug/status logic.

Test Plan:
1. AFR=0, ID word 0x12340000, DW1=0xDEADBEEF, raise req → o_fifo_w_en and o_rxok high one cycle during the cycle after E3; o_fifo_w_data matches frame; o_rx_ack high; drop req → ack low, state IDLE.
2. AFR=0001, AFMR0=0xFFE00000, AFIR0=0x24600000: ID 0x24600000 → stored with rxok; ID 0x24800000 → acked, no w_en/rxok/rxofl.
3. Accepted frame with i_rx_full=1 → o_rxofl one-cycle pulse, o_fifo_w_en=0, o_rxok=0, ack completes.
4. i_cen=0 with matching frame → ack completes, all strobes 0; i_cen toggled to 1 while in ACK → no retroactive write.
5. Req held high 20 cycles after ack → exactly one write; two back-to-back handshakes with different frames → two writes in order with correct data.
6. Assert i_reset while in FILTER → all outputs 0 same cycle, no write; release, send new frame → normal store with rxok.

Source files
------------

// File: rtl/can_rx_pkg.sv
// Shared types and field positions for the CAN receive acceptance path.
package can_rx_pkg;

  localparam int DEF_NUM_FILTERS = 4;
  localparam int DEF_FRAME_W     = 128;

  // Frame word boundaries inside the 128-bit frame
  localparam int ID_HI  = 127;
  localparam int ID_LO  = 96;
  localparam int DLC_HI = 95;
  localparam int DW1_HI = 63;
  localparam int DW2_HI = 31;

  // Bit positions inside the ID word
  localparam int IDH_HI  = 31;
  localparam int IDH_LO  = 21;
  localparam int SRR_BIT = 20;
  localparam int IDE_BIT = 19;
  localparam int IDL_HI  = 18;
  localparam int IDL_LO  = 1;
  localparam int RTR_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_STORE  = 2'd2,
    ST_ACK    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/can_acceptance_filter.sv
// Combinational acceptance check of one ID word against all mask/ID pairs.
module can_acceptance_filter
  import can_rx_pkg::*;
#(
  parameter int NUM_FILTERS = DEF_NUM_FILTERS
) (
  input  logic [31:0]               id,
  input  logic [NUM_FILTERS-1:0]    i_afr,
  input  logic [32*NUM_FILTERS-1:0] i_afmr,
  input  logic [32*NUM_FILTERS-1:0] i_afir,
  output logic                      accept
);

  logic [NUM_FILTERS-1:0][31:0] afmr_a;
  logic [NUM_FILTERS-1:0][31:0] afir_a;
  logic [NUM_FILTERS-1:0]       match;

  assign afmr_a = i_afmr;
  assign afir_a = i_afir;

  // Full 32-bit compare; software clears mask bits it wants ignored
  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_flt
    assign match[k] = i_afr[k] && (((id ^ afir_a[k]) & afmr_a[k]) == 32'd0);
  end

  // No enabled filter means filtering is off and everything is accepted
  assign accept = (i_afr == '0) || (|match);

endmodule

// File: rtl/can_rx_accept_logic.sv
// Receive-side frame handoff: req/ack from the CAN domain, acceptance
// filtering, RX FIFO write and RXOK/RXOFLW status pulses.
module can_rx_accept_logic
  import can_rx_pkg::*;
#(
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int FRAME_W     = DEF_FRAME_W
) (
  input  logic                      i_sys_clk,
  input  logic                      i_reset,
  input  logic                      i_cen,
  input  logic                      i_rx_req,
  input  logic [FRAME_W-1:0]        i_rx_frame,
  input  logic [NUM_FILTERS-1:0]    i_afr,
  input  logic [32*NUM_FILTERS-1:0] i_afmr,
  input  logic [32*NUM_FILTERS-1:0] i_afir,
  input  logic                      i_rx_full,
  output logic                      o_rx_ack,
  output logic                      o_fifo_w_en,
  output logic [FRAME_W-1:0]        o_fifo_w_data,
  output logic                      o_rxok,
  output logic                      o_rxofl
);

  rx_state_e          state, state_nxt;
  logic               t_req, s_req;
  logic [FRAME_W-1:0] frame_q;
  logic               accept;
  logic               load, w_en_d, rxofl_d, ack_d;

  can_acceptance_filter #(.NUM_FILTERS(NUM_FILTERS)) u_filter (
    .id     (frame_q[ID_HI:ID_LO]),
    .i_afr  (i_afr),
    .i_afmr (i_afmr),
    .i_afir (i_afir),
    .accept (accept)
  );

  // Two-flop synchronizer for the request level; the frame bus is not
  // synchronized because the handshake keeps it stable while req is high
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      t_req <= 1'b0;
      s_req <= 1'b0;
    end else begin
      t_req <= i_rx_req;
      s_req <= t_req;
    end
  end

  // State register
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: one pass per request; ACK waits for req to drop
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (s_req) state_nxt = ST_FILTER;
      ST_FILTER: state_nxt = ST_STORE;
      ST_STORE:  state_nxt = ST_ACK;
      ST_ACK:    if (!s_req) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; config and FIFO-full only matter on the FILTER exit edge
  always_comb begin
    load    = (state == ST_IDLE) && s_req;
    w_en_d  = (state == ST_FILTER) && i_cen && accept && !i_rx_full;
    rxofl_d = (state == ST_FILTER) && i_cen && accept && i_rx_full;
    ack_d   = (state_nxt == ST_ACK);
  end

  // Registered outputs and frame holding register
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      frame_q     <= '0;
      o_fifo_w_en <= 1'b0;
      o_rxok      <= 1'b0;
      o_rxofl     <= 1'b0;
      o_rx_ack    <= 1'b0;
    end else begin
      if (load) frame_q <= i_rx_frame;
      o_fifo_w_en <= w_en_d;
      o_rxok      <= w_en_d;
      o_rxofl     <= rxofl_d;
      o_rx_ack    <= ack_d;
    end
  end

  assign o_fifo_w_data = frame_q;

endmodule

// File: tb/tb_can_rx_accept_logic.sv
// Directed plus randomized checks of the RX acceptance path against a
// frame-level outcome model.
module tb_can_rx_accept_logic;

  localparam int NF = 4;
  localparam int FW = 128;

  logic            i_sys_clk = 1'b0;
  logic            i_reset;
  logic            i_cen;
  logic            i_rx_req;
  logic [FW-1:0]   i_rx_frame;
  logic [NF-1:0]   i_afr;
  logic [32*NF-1:0] i_afmr;
  logic [32*NF-1:0] i_afir;
  logic            i_rx_full;
  logic            o_rx_ack;
  logic            o_fifo_w_en;
  logic [FW-1:0]   o_fifo_w_data;
  logic            o_rxok;
  logic            o_rxofl;

  can_rx_accept_logic #(.NUM_FILTERS(NF), .FRAME_W(FW)) dut (
    .i_sys_clk     (i_sys_clk),
    .i_reset       (i_reset),
    .i_cen         (i_cen),
    .i_rx_req      (i_rx_req),
    .i_rx_frame    (i_rx_frame),
    .i_afr         (i_afr),
    .i_afmr        (i_afmr),
    .i_afir        (i_afir),
    .i_rx_full     (i_rx_full),
    .o_rx_ack      (o_rx_ack),
    .o_fifo_w_en   (o_fifo_w_en),
    .o_fifo_w_data (o_fifo_w_data),
    .o_rxok        (o_rxok),
    .o_rxofl       (o_rxofl)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  int errors = 0;
  int checks = 0;

  // Observed FIFO traffic
  int            wr_cnt = 0, rxok_cnt = 0, rxofl_cnt = 0;
  logic [FW-1:0] last_wdata = '0;
  // Expected FIFO traffic from the model
  int            e_wr = 0, e_rxok = 0, e_rxofl = 0;
  logic [FW-1:0] e_last = '0;

  // Monitor: count strobe cycles seen on the falling edge
  always @(negedge i_sys_clk) begin
    if (!i_reset) begin
      if (o_fifo_w_en) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= o_fifo_w_data;
      end
      if (o_rxok)  rxok_cnt  <= rxok_cnt + 1;
      if (o_rxofl) rxofl_cnt <= rxofl_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: accepted if filtering disabled or some enabled filter agrees on
  // every masked bit of the ID word
  function automatic bit model_accept(input logic [31:0] id, input logic [NF-1:0] afr,
                                      input logic [32*NF-1:0] afmr, input logic [32*NF-1:0] afir);
    bit acc;
    acc = (afr == '0);
    for (int k = 0; k < NF; k++) begin
      logic [31:0] m, ir;
      m  = afmr[32*k +: 32];
      ir = afir[32*k +: 32];
      if (afr[k] && ((id & m) == (ir & m))) acc = 1'b1;
    end
    return acc;
  endfunction

  // Predict outcome of one frame under the config currently applied
  task automatic predict(input logic [FW-1:0] f);
    if (i_cen && model_accept(f[127:96], i_afr, i_afmr, i_afir)) begin
      if (i_rx_full) e_rxofl++;
      else begin
        e_wr++;
        e_rxok++;
        e_last = f;
      end
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_wr"},    FW'(wr_cnt),    FW'(e_wr));
    check({tag, "_rxok"},  FW'(rxok_cnt),  FW'(e_rxok));
    check({tag, "_rxofl"}, FW'(rxofl_cnt), FW'(e_rxofl));
    check({tag, "_data"},  last_wdata,     e_last);
  endtask

  // Full handshake; optionally scramble config while in ACK
  task automatic send(input string tag, input logic [FW-1:0] f, input int hold, input bit scramble);
    int n;
    @(negedge i_sys_clk);
    i_rx_frame = f;
    i_rx_req   = 1'b1;
    n = 0;
    while (!o_rx_ack && n < 20) begin @(negedge i_sys_clk); n++; end
    check({tag, "_ack_up"}, FW'(o_rx_ack), FW'(1));
    if (scramble) begin
      i_cen     = ~i_cen;
      i_rx_full = ~i_rx_full;
      i_afr     = ~i_afr;
      i_afmr    = ~i_afmr;
    end
    repeat (hold) @(negedge i_sys_clk);
    i_rx_req = 1'b0;
    n = 0;
    while (o_rx_ack && n < 20) begin @(negedge i_sys_clk); n++; end
    check({tag, "_ack_dn"}, FW'(o_rx_ack), FW'(0));
    repeat (2) @(negedge i_sys_clk);
  endtask

  logic [FW-1:0] f;
  logic [31:0]   id;

  initial begin
    i_reset = 1'b1; i_cen = 1'b1; i_rx_req = 1'b0; i_rx_frame = '0;
    i_afr = '0; i_afmr = '0; i_afir = '0; i_rx_full = 1'b0;
    repeat (2) @(negedge i_sys_clk);
    check("rst_outs", FW'({o_rx_ack, o_fifo_w_en, o_rxok, o_rxofl}), FW'(0));
    check("rst_data", o_fifo_w_data, '0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_sys_clk);

    // 1: filtering off, exact latency of strobes and ack
    f = {32'h12340000, 32'h00000008, 32'hDEADBEEF, 32'h01020304};
    predict(f);
    @(negedge i_sys_clk);
    i_rx_frame = f;
    i_rx_req   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge i_sys_clk);
      check($sformatf("t1_wen_c%0d", c),  FW'(o_fifo_w_en), FW'(c == 4));
      check($sformatf("t1_rxok_c%0d", c), FW'(o_rxok),      FW'(c == 4));
      check($sformatf("t1_ack_c%0d", c),  FW'(o_rx_ack),    FW'(c >= 5));
      if (c == 4) check("t1_wdata", o_fifo_w_data, f);
    end
    i_rx_req = 1'b0;
    repeat (4) @(negedge i_sys_clk);
    check("t1_ack_low", FW'(o_rx_ack), FW'(0));
    verify("t1");

    // 2: single filter, match then miss
    i_afr = 4'b0001;
    i_afmr[31:0] = 32'hFFE00000;
    i_afir[31:0] = 32'h24600000;
    f = {32'h24600000, 32'h4, 32'hA5A5A5A5, 32'h5A5A5A5A};
    predict(f); send("t2a", f, 0, 0); verify("t2a");
    f = {32'h24800000, 32'h4, 32'h11111111, 32'h22222222};
    predict(f); send("t2b", f, 0, 0); verify("t2b");

    // 3: accepted frame into full FIFO -> overflow pulse only
    i_rx_full = 1'b1;
    f = {32'h24600000, 32'h2, 32'h33333333, 32'h44444444};
    predict(f); send("t3", f, 0, 0); verify("t3");
    i_rx_full = 1'b0;

    // 4: core disabled; enabling during ACK must not write retroactively
    i_cen = 1'b0;
    f = {32'h24600000, 32'h1, 32'h55555555, 32'h66666666};
    predict(f);
    @(negedge i_sys_clk);
    i_rx_frame = f; i_rx_req = 1'b1;
    repeat (6) @(negedge i_sys_clk);
    check("t4_ack", FW'(o_rx_ack), FW'(1));
    i_cen = 1'b1;
    repeat (3) @(negedge i_sys_clk);
    i_rx_req = 1'b0;
    repeat (5) @(negedge i_sys_clk);
    check("t4_ack_low", FW'(o_rx_ack), FW'(0));
    verify("t4");

    // 5: req held long after ack, then two back-to-back frames
    i_afr = '0;
    f = {32'hCAFE0001, 32'h8, 32'h77777777, 32'h88888888};
    predict(f); send("t5a", f, 20, 0); verify("t5a");
    f = {32'hCAFE0002, 32'h8, 32'h99999999, 32'hAAAAAAAA};
    predict(f); send("t5b", f, 0, 0); verify("t5b");
    f = {32'hCAFE0003, 32'h8, 32'hBBBBBBBB, 32'hCCCCCCCC};
    predict(f); send("t5c", f, 0, 0); verify("t5c");

    // 6: reset while in FILTER discards frame; next frame stores normally
    f = {32'h0BAD0000, 32'h8, 32'hDDDDDDDD, 32'hEEEEEEEE};
    @(negedge i_sys_clk);
    i_rx_frame = f; i_rx_req = 1'b1;
    repeat (3) @(negedge i_sys_clk);
    i_reset = 1'b1;
    #1;
    check("t6_outs", FW'({o_rx_ack, o_fifo_w_en, o_rxok, o_rxofl}), FW'(0));
    check("t6_data", o_fifo_w_data, '0);
    i_rx_req = 1'b0;
    repeat (3) @(negedge i_sys_clk);
    i_reset = 1'b0;
    repeat (3) @(negedge i_sys_clk);
    check("t6_nowrite", FW'(wr_cnt), FW'(e_wr));
    f = {32'h600D0000, 32'h8, 32'h13579BDF, 32'h2468ACE0};
    predict(f); send("t6b", f, 0, 0); verify("t6b");

    // Random frames and configs; config scrambled during ACK on some
    for (int i = 0; i < 40; i++) begin
      id = $urandom;
      f  = {id, $urandom, $urandom, $urandom};
      i_cen     = ($urandom_range(0, 7) != 0);
      i_rx_full = ($urandom_range(0, 4) == 0);
      i_afr     = ($urandom_range(0, 4) == 0) ? '0 : NF'($urandom);
      for (int k = 0; k < NF; k++) begin
        i_afmr[32*k +: 32] = $urandom;
        i_afir[32*k +: 32] = ($urandom_range(0, 1) == 1)
                           ? (id ^ (32'($urandom) & ~i_afmr[32*k +: 32]))
                           : 32'($urandom);
      end
      predict(f);
      send($sformatf("r%0d", i), f, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
      verify($sformatf("r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
